// File: rtl/matmult_host_if.sv
// SPI link and slave status lines between matmult_host (master) and the matmult slave.
interface matmult_host_if;
    logic spi_clk;
    logic cs;
    logic mosi;
    logic miso;
    logic slave_ready;
    logic slave_txn_ready;
    logic slave_calc_done;

    modport master (
        output spi_clk, cs, mosi,
        input  miso, slave_ready, slave_txn_ready, slave_calc_done
    );

    modport slave (
        input  spi_clk, cs, mosi,
        output miso, slave_ready, slave_txn_ready, slave_calc_done
    );
endinterface

// File: rtl/matmult_host.sv
// SPI master sequencer for the matmult slave: loads two 2x2 8-bit operands,
// waits for the calculation, then reads back four 18-bit products.
module matmult_host #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic           sys_clk,
    input  logic           rst,
    input  logic           start,
    input  logic [31:0]    mat_a,
    input  logic [31:0]    mat_b,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [71:0]    result,
    matmult_host_if.master spi
);
    typedef enum logic [2:0] {
        IDLE, WAIT_TXN, LOAD, WAIT_CALC, WAIT_RDY, READ, DONE, ERR
    } state_t;

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t           state, next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       half_cnt;
    logic [TMO_W-1:0] wait_cnt;
    logic [63:0]      tx_sr;
    logic [17:0]      rx_sr;
    logic [1:0]       word_idx;
    logic             sclk;
    logic             cs;
    logic             in_frame, waiting, tick, frame_end, timed_out;
    logic [7:0]       frame_halves;

    // A frame is 2*N+1 half-periods: setup half, N clock pulses, then a hold half before cs rises.
    assign in_frame     = (state == LOAD) || (state == READ);
    assign waiting      = (state == WAIT_TXN) || (state == WAIT_CALC) || (state == WAIT_RDY);
    assign frame_halves = (state == LOAD) ? 8'd128 : 8'd36;
    assign tick         = in_frame && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_end    = tick && (half_cnt == frame_halves);
    assign timed_out    = wait_cnt == TMO_W'(TIMEOUT - 1);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = WAIT_TXN;
            WAIT_TXN:  if (spi.slave_txn_ready) next_state = LOAD;
                       else if (timed_out)      next_state = ERR;
            LOAD:      if (frame_end) next_state = WAIT_CALC;
            WAIT_CALC: if (spi.slave_calc_done) next_state = WAIT_RDY;
                       else if (timed_out)      next_state = ERR;
            WAIT_RDY:  if (spi.slave_ready)     next_state = READ;
                       else if (timed_out)      next_state = ERR;
            READ:      if (frame_end) next_state = (word_idx == 2'd3) ? DONE : WAIT_RDY;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        error = 1'b0;
        cs    = 1'b1;
        case (state)
            WAIT_TXN, WAIT_CALC, WAIT_RDY: busy = 1'b1;
            LOAD, READ: begin
                busy = 1'b1;
                cs   = 1'b0;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    assign spi.cs      = cs;
    assign spi.spi_clk = sclk;
    assign spi.mosi    = (state == LOAD) & tx_sr[63];

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            sclk     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            word_idx <= '0;
            result   <= '0;
        end else begin
            if (state == IDLE && start) begin
                tx_sr    <= {mat_a[7:0], mat_a[15:8], mat_a[23:16], mat_a[31:24],
                             mat_b[7:0], mat_b[15:8], mat_b[23:16], mat_b[31:24]};
                result   <= '0;
                word_idx <= '0;
            end
            if (!in_frame) begin
                div_cnt  <= '0;
                half_cnt <= '0;
                sclk     <= 1'b0;
            end else if (!tick) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 8'd1;
                if (frame_end) begin
                    if (state == READ) begin
                        result[18*word_idx +: 18] <= rx_sr;
                        word_idx                  <= word_idx + 2'd1;
                    end
                end else if (!half_cnt[0]) begin
                    sclk  <= 1'b1;
                    rx_sr <= {rx_sr[16:0], spi.miso};
                end else begin
                    sclk  <= 1'b0;
                    tx_sr <= {tx_sr[62:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_matmult_host.sv
// Self-checking bench for matmult_host with a behavioural SPI slave and matrix-product model.
`timescale 1ns/1ps
module tb_matmult_host;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned TIMEOUT = 600;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] mat_a   = '0;
    logic [31:0] mat_b   = '0;
    logic        busy, done, error;
    logic [71:0] result;

    matmult_host_if spi_bus ();

    matmult_host #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .start  (start),
        .mat_a  (mat_a),
        .mat_b  (mat_b),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result),
        .spi    (spi_bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_cs_falls = 0;
    logic        prev_cs    = 1'b1;
    logic [1:0]  exp_kind   = 2'd0;   // 0: no completion due, 1: done, 2: error
    logic [71:0] exp_result = '0;
    logic [71:0] held       = '0;
    logic [63:0] last_load  = '0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // C = A*B with a = {a11,a10,a01,a00}; result packed {c11,c10,c01,c00}.
    function automatic logic [71:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [71:0] r;
        int unsigned c;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                c = 32'(a[8*(2*i) +: 8]) * 32'(b[8*j +: 8])
                  + 32'(a[8*(2*i+1) +: 8]) * 32'(b[8*(2+j) +: 8]);
                r[18*(2*i+j) +: 18] = c[17:0];
            end
        return r;
    endfunction

    function automatic logic [63:0] load_bits(input logic [31:0] a, input logic [31:0] b);
        return {a[7:0], a[15:8], a[23:16], a[31:24], b[7:0], b[15:8], b[23:16], b[31:24]};
    endfunction

    always @(negedge sys_clk) begin
        if (prev_cs === 1'b1 && spi_bus.cs === 1'b0) n_cs_falls++;
        prev_cs = spi_bus.cs;
        if (spi_bus.cs !== 1'b0) check("spi_clk_low_while_cs_high", 72'(spi_bus.spi_clk), 72'(0));
        if (rst) begin
            if (done || error) begin
                check("completion_kind", 72'({done, error}),
                      72'(exp_kind == 2'd1 ? 2'b10 : (exp_kind == 2'd2 ? 2'b01 : 2'b00)));
                check("result_at_completion", result, exp_result);
                check("busy_at_completion", 72'(busy), 72'(0));
                held     = exp_result;
                exp_kind = 2'd0;
            end else if (!busy) begin
                check("result_held", result, held);
            end
        end
    end

    // Slave side of one cs-low frame; miso changes after each observed falling spi_clk.
    task automatic frame(input bit is_read, input logic [17:0] word, input int dly, input bit glitch,
                         output logic [63:0] rx, output int rises);
        int   guard;
        logic prev;
        rx = '0; rises = 0; prev = 1'b0; guard = 0;
        spi_bus.miso = is_read ? word[17] : 1'b0;
        repeat (dly) @(negedge sys_clk);
        if (is_read) spi_bus.slave_ready = 1'b1;
        else         spi_bus.slave_txn_ready = 1'b1;
        while (spi_bus.cs !== 1'b0 && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
        end
        spi_bus.slave_ready     = 1'b0;
        spi_bus.slave_txn_ready = 1'b0;
        while (spi_bus.cs === 1'b0 && guard < 4000) begin
            if (spi_bus.spi_clk && !prev) begin
                rx = {rx[62:0], spi_bus.mosi};
                rises++;
            end
            if (!spi_bus.spi_clk && prev) spi_bus.miso = (rises < 18) ? word[17 - rises] : 1'b0;
            if (glitch) spi_bus.slave_txn_ready = (rises == 5);
            prev = spi_bus.spi_clk;
            @(negedge sys_clk);
            guard++;
        end
        spi_bus.slave_txn_ready = 1'b0;
        check("frame_within_bound", 72'(guard < 4000), 72'(1));
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input bit pre,
                           input bit disturb, input bit start_at_done, output logic [71:0] got);
        logic [63:0] rx;
        logic [71:0] c_slave;
        int          rises, guard;
        exp_result = matmul(a, b);
        exp_kind   = 2'd1;
        if (pre) spi_bus.slave_txn_ready = 1'b1;
        mat_a = a; mat_b = b; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("busy_after_accept", 72'(busy), 72'(1));
        if (disturb) begin
            mat_a = $urandom; mat_b = $urandom; start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
        end
        frame(1'b0, '0, pre ? 0 : int'($urandom_range(0, 30)), 1'b0, rx, rises);
        last_load = rx;
        check("load_bits", 72'(rx), 72'(load_bits(a, b)));
        check("load_clocks", 72'(rises), 72'(64));
        c_slave = matmul({rx[39:32], rx[47:40], rx[55:48], rx[63:56]},
                         {rx[7:0], rx[15:8], rx[23:16], rx[31:24]});
        repeat ($urandom_range(0, 30)) @(negedge sys_clk);
        spi_bus.slave_calc_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            frame(1'b1, c_slave[18*k +: 18], int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), rx, rises);
            check("read_clocks", 72'(rises), 72'(18));
        end
        spi_bus.slave_calc_done = 1'b0;
        guard = 0;
        while (!done && guard < 100) begin
            @(negedge sys_clk);
            guard++;
        end
        check("done_seen", 72'(done), 72'(1));
        got = result;
        if (start_at_done) begin
            mat_a = $urandom; start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
            check("start_at_done_ignored", 72'(busy), 72'(0));
        end else begin
            @(negedge sys_clk);
        end
        check("busy_low_after", 72'(busy), 72'(0));
    endtask

    initial begin
        logic [71:0] got;
        logic [31:0] ra, rb;
        int          n, cs_low, rises, falls0;
        logic        prev;
        spi_bus.miso = 1'b0;
        spi_bus.slave_ready = 1'b0;
        spi_bus.slave_txn_ready = 1'b0;
        spi_bus.slave_calc_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_flags", 72'({busy, done, error, spi_bus.cs, spi_bus.spi_clk, spi_bus.mosi}), 72'(6'b000100));
        check("reset_result", result, '0);
        rst = 1'b1;
        @(negedge sys_clk);

        falls0 = n_cs_falls;
        run_txn(32'h04030201, 32'h08070605, 1'b0, 1'b0, 1'b0, got);
        check("t1_result_literal", got, {18'd50, 18'd43, 18'd22, 18'd19});
        check("t2_load_literal", 72'(last_load), 72'(64'h0102030405060708));
        check("t2_cs_frames", 72'(n_cs_falls - falls0), 72'(5));

        run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, got);
        check("t3_result_literal", got, {4{18'h1FC02}});

        ra = $urandom; rb = $urandom;
        run_txn(ra, rb, 1'b0, 1'b1, 1'b1, got);
        check("t6_first_operands", got, matmul(ra, rb));

        for (int t = 0; t < 5; t++) begin
            ra = $urandom; rb = $urandom;
            run_txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
            check("random_result", got, matmul(ra, rb));
        end

        exp_result = '0;
        exp_kind   = 2'd2;
        mat_a = $urandom; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        n = 0; cs_low = 0;
        while (!error && n < int'(TIMEOUT) + 50) begin
            @(negedge sys_clk);
            n++;
            if (spi_bus.cs !== 1'b1) cs_low++;
        end
        check("t4_timeout_cycles", 72'(n), 72'(TIMEOUT));
        check("t4_cs_idle", 72'(cs_low), 72'(0));
        @(negedge sys_clk);
        check("t4_busy_low", 72'(busy), 72'(0));

        exp_kind = 2'd0;
        spi_bus.slave_txn_ready = 1'b1;
        mat_a = $urandom; mat_b = $urandom; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 20 && n < 2000) begin
            if (spi_bus.cs === 1'b0) spi_bus.slave_txn_ready = 1'b0;
            if (spi_bus.spi_clk && !prev) rises++;
            prev = spi_bus.spi_clk;
            @(negedge sys_clk);
            n++;
        end
        check("t5_reached_byte3", 72'(rises), 72'(20));
        #2 rst = 1'b0;
        held = '0;
        spi_bus.slave_txn_ready = 1'b0;
        #1;
        check("t5_async_reset", 72'({spi_bus.cs, spi_bus.spi_clk, busy}), 72'(3'b100));
        check("t5_reset_result", result, '0);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        ra = $urandom; rb = $urandom;
        run_txn(ra, rb, 1'b0, 1'b0, 1'b0, got);
        check("t5_recovery_result", got, matmul(ra, rb));

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at 3 ms, required to finish earlier");
        $fatal(1, "watchdog expired");
    end
endmodule
